// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle control sequencer and the datapath top:
// FSM state encodings, opcode field values, write-back source codes.
package seq_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_IMM   = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_IMM = 2'b10;

    // STORE writes nothing back, so it shares the ALU code.
    function automatic logic [1:0] wb_code(input logic [1:0] op);
        logic [1:0] code;
        code = WB_ALU;
        case (op)
            OP_LOAD: code = WB_MEM;
            OP_IMM:  code = WB_IMM;
            default: code = WB_ALU;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seq_out_decode.sv
// Moore output decode for the sequencer: every strobe is a pure function of the
// registered state and the latched opcode, so each one is glitch-free per cycle.
module seq_out_decode
    import seq_pkg::*;
(
    input  logic [2:0] state,
    input  logic [1:0] op,
    output logic       instr_ready,
    output logic       pc_en,
    output logic       reg_we,
    output logic       mem_re,
    output logic       mem_we,
    output logic [1:0] wb_sel,
    output logic       busy
);

    // Decode strobes; pc_en marks the final cycle of an instruction (WB, or MEM for a store).
    always_comb begin
        instr_ready = 1'b0;
        pc_en       = 1'b0;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        wb_sel      = WB_ALU;
        busy        = (state != ST_IDLE);
        case (state)
            ST_FETCH: begin
                instr_ready = 1'b1;
            end
            ST_DECODE, ST_EXEC: begin
                wb_sel = wb_code(op);
            end
            ST_MEM: begin
                wb_sel = wb_code(op);
                mem_re = (op == OP_LOAD);
                mem_we = (op == OP_STORE);
                pc_en  = (op != OP_LOAD);
            end
            ST_WB: begin
                wb_sel = wb_code(op);
                reg_we = 1'b1;
                pc_en  = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: fetches one instruction byte over valid/ready,
// steps it through decode/execute/memory/write-back and counts retired instructions.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [7:0]       instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [7:0]       ir,
    output logic             pc_en,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic [1:0]       wb_sel,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_e             state_q, state_d;
    logic [7:0]         ir_q, ir_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    seq_out_decode u_out_decode (
        .state       (state_q),
        .op          (ir_q[7:6]),
        .instr_ready (instr_ready),
        .pc_en       (pc_en),
        .reg_we      (reg_we),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .wb_sel      (wb_sel),
        .busy        (busy)
    );

    // Next state, instruction capture and retire count; step is only honoured in IDLE.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (run || step) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (ir_q[7:6])
                    OP_ALU:  state_d = ST_EXEC;
                    OP_IMM:  state_d = ST_WB;
                    default: state_d = ST_MEM;
                endcase
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_MEM: begin
                if (ir_q[7:6] == OP_LOAD) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_WB;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The last cycle of an instruction retires it and either chains or parks.
        if (pc_en) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = run ? ST_FETCH : ST_IDLE;
        end
    end

    // State, instruction and counter registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ir_q      <= 8'h00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign ir      = ir_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a stage-list model of each
// instruction is compared against the DUT every cycle, alongside directed scenarios.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic             step = 1'b0;
    logic [7:0]       instr = 8'h00;
    logic             instr_valid = 1'b0;
    logic             instr_ready;
    logic [7:0]       ir;
    logic             pc_en;
    logic             reg_we;
    logic             mem_re;
    logic             mem_we;
    logic [1:0]       wb_sel;
    logic             busy;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ir          (ir),
        .pc_en       (pc_en),
        .reg_we      (reg_we),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .wb_sel      (wb_sel),
        .busy        (busy),
        .state       (state),
        .retired     (retired)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Reference model: an instruction is a list of post-fetch stages taken from its latency.
    int         mStage = 0;
    logic [7:0] mIr = 8'h00;
    int         mRetired = 0;
    int         mStages[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mStage   = 0;
            mIr      = 8'h00;
            mRetired = 0;
            mStages.delete();
        end else begin
            if (mStage == 0) begin
                if (run || step) mStage = 1;
            end else if (mStage == 1) begin
                if (instr_valid) begin
                    mIr = instr;
                    case (instr[7:6])
                        2'b00:   mStages = '{2, 3, 5};
                        2'b01:   mStages = '{2, 4, 5};
                        2'b10:   mStages = '{2, 4};
                        default: mStages = '{2, 5};
                    endcase
                    mStage = mStages.pop_front();
                end
            end else if (mStages.size() > 0) begin
                mStage = mStages.pop_front();
            end else begin
                mRetired = (mRetired + 1) % (1 << CNT_W);
                mStage   = run ? 1 : 0;
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h time=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        logic [1:0] op;
        logic [1:0] expWb;
        bit         endNow;
        op     = mIr[7:6];
        expWb  = (op == 2'b01) ? 2'b01 : ((op == 2'b11) ? 2'b10 : 2'b00);
        endNow = (mStage >= 2) && (mStages.size() == 0);
        checkValue("state",       32'(state),       32'(mStage));
        checkValue("busy",        32'(busy),        32'(mStage != 0));
        checkValue("instr_ready", 32'(instr_ready), 32'(mStage == 1));
        checkValue("pc_en",       32'(pc_en),       32'(endNow));
        checkValue("reg_we",      32'(reg_we),      32'(mStage == 5));
        checkValue("mem_re",      32'(mem_re),      32'(mStage == 4 && op == 2'b01));
        checkValue("mem_we",      32'(mem_we),      32'(mStage == 4 && op == 2'b10));
        checkValue("ir",          32'(ir),          32'(mIr));
        checkValue("retired",     32'(retired),     32'(mRetired));
        if (mStage >= 2) checkValue("wb_sel", 32'(wb_sel), 32'(expWb));
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmpEn) checkOutput();
    end

    task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [7:0] ins);
        @(posedge clk);
        #2;
        run         = r;
        step        = s;
        instr_valid = v;
        instr       = ins;
    endtask

    task automatic waitState(input int target, input int maxCycles, input string name);
        bit found;
        found = 1'b0;
        for (int c = 0; c < maxCycles && !found; c++) begin
            @(negedge clk);
            if (32'(state) == target) found = 1'b1;
        end
        checkValue(name, 32'(found), 32'd1);
    endtask

    logic [7:0] prog [3] = '{8'h46, 8'h8C, 8'hC3};
    int         expSeq [6] = '{0, 1, 2, 3, 5, 0};
    logic [2:0] sLog [6];
    logic       rwLog [6];
    logic       pcLog [6];
    logic [1:0] wbLog [6];

    initial begin
        int  accepted;
        int  busyCnt;
        int  memReCnt;
        int  memWeCnt;
        int  regWeCnt;
        logic [1:0] immWb;
        bit  seen;
        bit  done;

        // Reset held low: reset values visible.
        repeat (2) @(posedge clk);
        #1;
        checkValue("rst_state",   32'(state),       32'd0);
        checkValue("rst_ir",      32'(ir),          32'h00);
        checkValue("rst_retired", 32'(retired),     32'd0);
        checkValue("rst_ready",   32'(instr_ready), 32'd0);
        checkValue("rst_busy",    32'(busy),        32'd0);
        checkValue("rst_pc_en",   32'(pc_en),       32'd0);
        checkValue("rst_wb_sel",  32'(wb_sel),      32'd0);
        #1 reset = 1'b1;
        cmpEn = 1'b1;
        repeat (10) @(negedge clk);
        checkValue("idle_state",   32'(state),   32'd0);
        checkValue("idle_retired", 32'(retired), 32'd0);

        // Single step of ALU instruction 8'h1B.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h1B);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sLog[i]  = state;
            rwLog[i] = reg_we;
            pcLog[i] = pc_en;
            wbLog[i] = wb_sel;
            if (i == 0) applyStimulus(1'b0, 1'b0, 1'b1, 8'h1B);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            checkValue($sformatf("alu_state[%0d]", i), 32'(sLog[i]), 32'(expSeq[i]));
            checkValue($sformatf("alu_reg_we[%0d]", i), 32'(rwLog[i]), 32'(i == 4));
            checkValue($sformatf("alu_pc_en[%0d]", i), 32'(pcLog[i]), 32'(i == 4));
            if (i >= 2 && i <= 4) checkValue($sformatf("alu_wb_sel[%0d]", i), 32'(wbLog[i]), 32'd0);
        end
        checkValue("alu_retired", 32'(retired), 32'd1);

        // Continuous run over LOAD, STORE, IMM.
        accepted = 0; busyCnt = 0; memReCnt = 0; memWeCnt = 0; regWeCnt = 0;
        immWb = 2'b11; seen = 1'b0; done = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, prog[0]);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (busy) begin busyCnt++; seen = 1'b1; end
            if (mem_re) memReCnt++;
            if (mem_we) memWeCnt++;
            if (reg_we) regWeCnt++;
            if (state == 3'd5 && ir == 8'hC3) immWb = wb_sel;
            if (seen && state == 3'd0) begin
                done = 1'b1;
            end else if (state == 3'd1 && instr_valid) begin
                accepted++;
                if (accepted < 3) applyStimulus(1'b1, 1'b0, 1'b1, prog[accepted]);
                else              applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
            end
        end
        checkValue("mix_done",     32'(done),     32'd1);
        checkValue("mix_busy_cyc", 32'(busyCnt),  32'd10);
        checkValue("mix_mem_re",   32'(memReCnt), 32'd1);
        checkValue("mix_mem_we",   32'(memWeCnt), 32'd1);
        checkValue("mix_reg_we",   32'(regWeCnt), 32'd2);
        checkValue("mix_imm_wb",   32'(immWb),    32'd2);
        checkValue("mix_retired",  32'(retired),  32'd4);

        // Fetch stall with instr_valid low.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkValue("stall_state", 32'(state),       32'd1);
            checkValue("stall_ready", 32'(instr_ready), 32'd1);
            checkValue("stall_ir",    32'(ir),          32'hC3);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A);
        waitState(0, 20, "stall_done");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkValue("stall_ir_new",  32'(ir),      32'h5A);
        checkValue("stall_retired", 32'(retired), 32'd5);

        // run drops while the ALU instruction is in EXEC.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h1B);
        waitState(2, 20, "rundrop_decode");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h1B);
        waitState(0, 20, "rundrop_idle");
        repeat (3) begin
            @(negedge clk);
            checkValue("rundrop_stay", 32'(state), 32'd0);
        end
        checkValue("rundrop_retired", 32'(retired), 32'd6);

        // step pulse during DECODE must be ignored.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hC1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC1);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'hC1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hC1);
        repeat (6) @(negedge clk);
        checkValue("stepign_state",   32'(state),   32'd0);
        checkValue("stepign_retired", 32'(retired), 32'd7);

        // Asynchronous reset while a STORE is in MEM.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h8C);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h8C);
        waitState(2, 10, "store_decode");
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkValue("arst_state",   32'(state),   32'd0);
        checkValue("arst_mem_we",  32'(mem_we),  32'd0);
        checkValue("arst_pc_en",   32'(pc_en),   32'd0);
        checkValue("arst_busy",    32'(busy),    32'd0);
        checkValue("arst_ir",      32'(ir),      32'h00);
        checkValue("arst_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #2;
        step        = 1'b0;
        instr_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        checkValue("arst_after", 32'(retired), 32'd0);

        // Counter wrap: 17 IMM instructions with a 4-bit counter.
        accepted = 0;
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hC2);
        for (int c = 0; c < 100 && accepted < 17; c++) begin
            @(negedge clk);
            if (state == 3'd1 && instr_valid) begin
                accepted++;
                if (accepted == 17) applyStimulus(1'b0, 1'b0, 1'b0, 8'hC2);
            end
        end
        checkValue("wrap_accepted", 32'(accepted), 32'd17);
        waitState(0, 10, "wrap_idle");
        checkValue("wrap_retired", 32'(retired), 32'd1);

        cmpEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
